hamming_decoder_7_4: RTL

//  Receive-side counterpart of the team's Hamming(7,4) encoder.
//  - Accepts 7-bit codewords over a valid/ready interface and computes the 3-bit syndrome.
//  - Corrects any single-bit error and returns the 4 data bits through a 2-stage pipeline with backpressure.
//  - Keeps a saturating count of corrected words for system status.

---
 rtl/hamming_pkg.sv | 48 ++++
 rtl/hamming_syndrome_corr.sv | 29 ++
 rtl/hamming_decoder_7_4.sv | 87 ++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) constants and helpers used by the encoder and decoder.
// Codeword layout (bit6..0) = {d3,d2,d1,p4,d0,p2,p1}; Hamming position = bit index + 1.
// Pure functions only; no state.
`timescale 1ns/1ps
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Bit indices inside the 7-bit codeword
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;

  // Syndrome {s4,s2,s1}: each bit rechecks even parity over its group
  function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] code);
    logic s1, s2, s4;
    s1 = code[P1] ^ code[D0] ^ code[D1] ^ code[D3];
    s2 = code[P2] ^ code[D0] ^ code[D2] ^ code[D3];
    s4 = code[P4] ^ code[D1] ^ code[D2] ^ code[D3];
    return {s4, s2, s1};
  endfunction

  // Data bits {d3,d2,d1,d0} pulled out of a codeword
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    return {code[D3], code[D2], code[D1], code[D0]};
  endfunction

  // Transmit-side encoder, kept here so both directions share one layout
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] code;
    code     = '0;
    code[D0] = data[0];
    code[D1] = data[1];
    code[D2] = data[2];
    code[D3] = data[3];
    code[P1] = data[0] ^ data[1] ^ data[3];
    code[P2] = data[0] ^ data[2] ^ data[3];
    code[P4] = data[1] ^ data[2] ^ data[3];
    return code;
  endfunction

endpackage

// File: rtl/hamming_syndrome_corr.sv
// Combinational syndrome + single-bit correction of one Hamming(7,4) codeword.
// Latency: 0 cycles (pure logic).
// Backpressure: none; the enclosing pipeline decides when results are captured.
`timescale 1ns/1ps
module hamming_syndrome_corr
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syn,
  output logic [DATA_W-1:0] data
);

  logic [SYN_W-1:0]  syn_c;
  logic [CODE_W-1:0] flip;
  logic [CODE_W-1:0] fixed;

  // Nonzero syndrome names the 1-based position to invert; double errors miscorrect by design
  always_comb begin
    syn_c = syndrome(code);
    flip  = '0;
    if (syn_c != '0) begin
      flip = {{(CODE_W-1){1'b0}}, 1'b1} << (syn_c - 3'd1);
    end
    fixed = code ^ flip;
    syn   = syn_c;
    data  = extract_data(fixed);
  end

endmodule

// File: rtl/hamming_decoder_7_4.sv
// Hamming(7,4) receive decoder: syndrome, single-bit correction, saturating corrected-word count.
// Latency: 2 cycles from input handshake to out_valid, 1 word/cycle throughput.
// Backpressure: whole pipeline advances only when EN=1 and the output slot is empty or being taken.
`timescale 1ns/1ps
module hamming_decoder_7_4
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic [CODE_W-1:0] code_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_corrected,
  output logic [SYN_W-1:0]  err_pos,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt
);

  logic              adv;
  logic              cnt_inc;
  logic [SYN_W-1:0]  syn_c;
  logic [DATA_W-1:0] data_c;

  // Stage 1 keeps the syndrome and the already-corrected data, which is all stage 2 needs
  logic              s1_valid;
  logic [SYN_W-1:0]  s1_syn;
  logic [DATA_W-1:0] s1_data;

  // Single advance strobe: both stages move together, so a stall freezes everything
  assign adv      = EN & (~out_valid | out_ready);
  assign in_ready = adv;

  hamming_syndrome_corr u_corr (
    .code (code_in),
    .syn  (syn_c),
    .data (data_c)
  );

  // Stage 1: capture syndrome and corrected data of the incoming word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_syn   <= '0;
      s1_data  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_syn   <= syn_c;
      s1_data  <= data_c;
    end
  end

  // Stage 2: output registers, held stable while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      data_out      <= '0;
      err_pos       <= '0;
      err_corrected <= 1'b0;
    end else if (adv) begin
      out_valid     <= s1_valid;
      data_out      <= s1_data;
      err_pos       <= s1_syn;
      err_corrected <= (s1_syn != '0);
    end
  end

  // A word counts once, at the moment it moves into stage 2
  assign cnt_inc = adv & s1_valid & (s1_syn != '0);

  // Saturating corrected-word counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt <= '0;
    end else if (cnt_inc && (corr_cnt != {CNT_W{1'b1}})) begin
      corr_cnt <= corr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
